// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-to-decode handshake bundle for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                       in_valid;
    logic [63:0]                in_pc;
    logic [31:0]                in_instr;
    logic                       pc_en;
    logic                       out_valid;
    logic                       out_ready;
    logic [63:0]                out_pc;
    logic [31:0]                out_instr;
    logic [$clog2(DEPTH):0]     count;

    // Fetch/decode side
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  pc_en, out_valid, out_pc, out_instr, count
    );

    // Queue side
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output pc_en, out_valid, out_pc, out_instr, count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction queue between fetch and decode with
//               flush; optional zero-latency bypass via FETCH_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       flush,
    fetch_queue_if.slave    bus
);
    localparam int              c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL_COUNT = (c_AW+1)'(DEPTH);
    localparam logic [31:0]     c_NOP        = 32'h0000_0013;

    logic [95:0]        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && bus.in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry that decode takes immediately never touches storage.
    assign w_push = bus.in_valid && !w_full && !flush && !(w_bypass && bus.out_ready);
    assign w_pop  = !w_empty && bus.out_ready && !flush;

    assign bus.pc_en = !w_full && !reset;
    assign bus.count = r_count;

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_pc    = 64'h0;
        bus.out_instr = c_NOP;
        if (!w_empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = r_mem[r_rd_ptr][95:32];
            bus.out_instr = r_mem[r_rd_ptr][31:0];
        end else if (w_bypass) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = bus.in_pc;
            bus.out_instr = bus.in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never visible while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_instr};
        end
    end
endmodule
`default_nettype wire
